// File: rtl/uart_tx_sched_if.sv
// Register-bus interface for uart_tx_sched: select, write strobe, word
// address, write data and the combinational read-data return path.
interface uart_tx_sched_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: a small byte FIFO written over the register bus,
// drained one byte at a time into an external UART transmitter via a
// start pulse / busy handshake, with status, control and an idle interrupt.
module uart_tx_sched #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_sched_if.slave         bus,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ack_wait;
    logic            ack_wait_nxt;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            overflow;
    logic            enable;
    logic            irq_en;

    logic            bus_wr;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [4:0]      count_rd;
    logic            unused_wdata;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    assign bus_wr   = bus.sel & bus.we;
    assign push_req = bus_wr && (bus.addr == ADDR_DATA);
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok  = push_req & ~fifo_full;
    // The head byte leaves the FIFO on the IDLE -> START transition only.
    assign pop      = (state == IDLE) & enable & ~fifo_empty & ~tx_busy;

    // Start pulse is the START state itself, suppressed while reset is held.
    assign tx_start = (state == START) & ~reset;

    assign count_rd     = 5'(count);
    assign unused_wdata = &{1'b0, bus.wdata[31:8]};

    // FIFO storage: written on accepted pushes only.
    // NOTE: the storage array has no reset; entries are only read after being written, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output byte register: loaded with the FIFO head when it is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data <= 8'h00;
        end else if (pop) begin
            tx_data <= mem[rd_ptr];
        end
    end

    // Control/status registers: sticky overflow with write-one-to-clear, CTRL bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            enable   <= 1'b1;
            irq_en   <= 1'b0;
        end else begin
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (bus_wr && (bus.addr == ADDR_STATUS) && bus.wdata[2]) begin
                overflow <= 1'b0;
            end
            if (bus_wr && (bus.addr == ADDR_CTRL)) begin
                enable <= bus.wdata[0];
                irq_en <= bus.wdata[1];
            end
        end
    end

    // Interrupt flop: scheduler idle with nothing left to send.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & fifo_empty & (state == IDLE);
        end
    end

    // FSM state register and the two-cycle no-ack timer bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ack_wait <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_wait <= ack_wait_nxt;
        end
    end

    // FSM next-state logic; a silent transmitter times out after two WAIT_ACK cycles.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        ack_wait_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_wait) begin
                    state_nxt = IDLE;
                end else begin
                    ack_wait_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register read mux; unselected or reserved reads return zero.
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                ADDR_STATUS: begin
                    bus.rdata[0]    = fifo_empty;
                    bus.rdata[1]    = fifo_full;
                    bus.rdata[2]    = overflow;
                    bus.rdata[3]    = (state != IDLE);
                    bus.rdata[12:8] = count_rd;
                end
                ADDR_CTRL: begin
                    bus.rdata[0] = enable;
                    bus.rdata[1] = irq_en;
                end
                default: begin
                    bus.rdata = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning TX FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port sel  in  1  bus select for this block.
REQ-005 SHALL have port we  in  1  bus write strobe, qualified by sel.
REQ-006 SHALL have port addr  in  2  word offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-007 SHALL have port wdata  in  32  bus write data.
REQ-008 SHALL have port rdata  out  32  bus read data, combinational from addr.
REQ-009 SHALL have port tx_start  out  1  one-cycle start pulse to UART transmitter.
REQ-010 SHALL have port tx_data  out  8  byte to UART, held stable from tx_start until return to IDLE.
REQ-011 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-012 SHALL have port irq  out  1  registered, = irq_en & fifo_empty & (state==IDLE).

Function
REQ-013 SHALL treat sel&we&addr==0 as push of wdata[7:0]; DATA reads return 0.
REQ-014 SHALL read STATUS as: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 sending (state!=IDLE), bits[12:8] count, others 0.
REQ-015 SHALL clear overflow on STATUS write with wdata[2]=1 (W1C); other STATUS bits not writable.
REQ-016 SHALL read/write CTRL as: bit0 enable, bit1 irq_en, others read 0.
REQ-017 SHALL return 0 on rdata for addr 3 or when sel=0; writes to addr 3 ignored.
REQ-018 SHALL reject push when full (even if a pop occurs same cycle), dropping the byte and setting overflow.
REQ-019 SHALL wrap FIFO read/write pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 SHALL implement FSM IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-021 IDLE -> START when enable & !empty & !tx_busy; SHALL pop head into tx_data on this transition.
REQ-022 START: tx_start=1 for exactly this cycle; next state WAIT_ACK unconditionally.
REQ-023 WAIT_ACK: tx_busy=1 -> WAIT_DONE; if tx_busy stays 0 for 2 cycles in WAIT_ACK -> IDLE (byte considered sent).
REQ-024 WAIT_DONE: tx_busy=0 -> IDLE.
REQ-025 Latency: push accepted at edge N into empty FIFO while IDLE, enabled, tx_busy=0 -> tx_start high in cycle after edge N+1 (state START after edge N+1).
REQ-026 Clearing enable mid-transfer SHALL let the current byte complete; no further pop until enable=1.
REQ-027 Push while FSM busy SHALL be accepted if not full; bytes transmitted in FIFO order.
REQ-028 tx_start SHALL never assert while tx_busy was high in the preceding IDLE cycle.

Reset
REQ-029 On reset: state IDLE, FIFO empty, pointers/count 0, overflow 0, enable 1, irq_en 0, tx_start 0, tx_data 0x00, irq 0.
REQ-030 Reset mid-transfer SHALL abort immediately; queued bytes discarded; no tx_start on the reset cycle or the cycle after.

Verification
REQ-031 Single byte: push 0x41, UART model busy 10 cycles -> one tx_start, tx_data=0x41, STATUS.sending clears after busy falls, empty=1.
REQ-032 Ordering/wrap: push 0x01..0x0C over two bursts with drains between (pointers wrap) -> tx_data sequence 0x01..0x0C in order, no loss.
REQ-033 Overflow: enable=0, push 9 bytes (DEPTH=8) -> full=1, count=8, overflow=1, 9th byte absent; write STATUS 0x4 -> overflow=0.
REQ-034 No ack: tx_busy tied 0, push 0x55 -> tx_start once, FSM back to IDLE 3 cycles after START, no hang.
REQ-035 Enable/irq: irq_en=1, push 2 bytes, clear enable during first byte -> first completes, second stays queued, irq=0; set enable -> second sent, then irq=1.
REQ-036 Reset mid-transfer: assert reset in WAIT_DONE with 3 queued -> count=0, tx_start=0, state IDLE, CTRL reads 0x1.
